// File: rtl/msi_cache_ctrl_if.sv
// Processor-side and coherence-bus-side signals of one MSI cache controller.
// The controller uses the slave view; the processor/bus environment the master view.
interface msi_cache_ctrl_if #(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned CACHE_LINE_SIZE = 128
);
  // processor request/response
  logic                       pr_rd_i;
  logic                       pr_wr_i;
  logic [ADDR_SIZE-1:0]       pr_addr_i;
  logic [CACHE_LINE_SIZE-1:0] pr_wdata_i;
  logic [CACHE_LINE_SIZE-1:0] pr_rdata_o;
  logic                       pr_done_o;
  // requester side of the shared bus
  logic                       bus_req_o;
  logic                       bus_gnt_i;
  logic [1:0]                 bus_msg_o;
  logic [ADDR_SIZE-1:0]       bus_addr_o;
  // snooper side of the shared bus
  logic                       bus_valid_i;
  logic [1:0]                 bus_msg_i;
  logic [ADDR_SIZE-1:0]       bus_addr_i;
  logic [CACHE_LINE_SIZE-1:0] bus_data_i;
  logic                       flush_o;
  logic [CACHE_LINE_SIZE-1:0] flush_data_o;

  modport master (
    output pr_rd_i, pr_wr_i, pr_addr_i, pr_wdata_i,
    input  pr_rdata_o, pr_done_o,
    input  bus_req_o, bus_msg_o, bus_addr_o,
    output bus_gnt_i, bus_valid_i, bus_msg_i, bus_addr_i, bus_data_i,
    input  flush_o, flush_data_o
  );

  modport slave (
    input  pr_rd_i, pr_wr_i, pr_addr_i, pr_wdata_i,
    output pr_rdata_o, pr_done_o,
    output bus_req_o, bus_msg_o, bus_addr_o,
    input  bus_gnt_i, bus_valid_i, bus_msg_i, bus_addr_i, bus_data_i,
    output flush_o, flush_data_o
  );
endinterface

// File: rtl/msi_cache_ctrl.sv
// Per-processor MSI snoopy cache controller. Direct-mapped array of
// NUM_LINES lines; serves processor line reads/writes, requests the shared
// bus on misses, upgrades and dirty evictions, and snoops other caches'
// granted transactions to downgrade/invalidate and flush Modified lines.
module msi_cache_ctrl #(
  parameter int unsigned NUM_LINES       = 2,
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned CACHE_LINE_SIZE = 128
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  msi_cache_ctrl_if.slave cif
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_SIZE - IDX_W;

  typedef enum logic [1:0] {
    LS_I = 2'd0,
    LS_S = 2'd1,
    LS_M = 2'd2
  } line_state_e;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_WB   = 2'b11
  } bus_msg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_MISS,
    ST_DONE
  } fsm_e;

  // line array
  line_state_e                st_q   [NUM_LINES];
  logic [TAG_W-1:0]           tag_q  [NUM_LINES];
  logic [CACHE_LINE_SIZE-1:0] data_q [NUM_LINES];

  // controller state
  fsm_e                       fsm_q,   fsm_d;
  bus_msg_e                   msg_q,   msg_d;
  logic [CACHE_LINE_SIZE-1:0] rdata_q, rdata_d;

  // processor address split
  logic [IDX_W-1:0] pr_idx;
  logic [TAG_W-1:0] pr_tag;
  logic             pr_hit;

  // snooped address split
  logic [IDX_W-1:0] snp_idx;
  logic [TAG_W-1:0] snp_tag;
  logic             snp_act;
  logic             snp_hit;

  // line update from the processor side
  logic                       ln_we;
  line_state_e                ln_state;
  logic [TAG_W-1:0]           ln_tag;
  logic [CACHE_LINE_SIZE-1:0] ln_data;

  // line state update from the snoop side
  logic        snp_we;
  line_state_e snp_state;
  logic        snp_flush;

  // registered-output staging
  logic                       bus_req;
  bus_msg_e                   bus_msg;
  logic [ADDR_SIZE-1:0]       bus_addr;
  logic                       pr_done;
  logic [CACHE_LINE_SIZE-1:0] pr_rdata;
  logic                       wb_flush;

  assign pr_idx  = cif.pr_addr_i[IDX_W-1:0];
  assign pr_tag  = cif.pr_addr_i[ADDR_SIZE-1:IDX_W];
  assign pr_hit  = (st_q[pr_idx] != LS_I) && (tag_q[pr_idx] == pr_tag);

  assign snp_idx = cif.bus_addr_i[IDX_W-1:0];
  assign snp_tag = cif.bus_addr_i[ADDR_SIZE-1:IDX_W];
  // our own granted transaction is never snooped
  assign snp_act = cif.bus_valid_i && !cif.bus_gnt_i;
  assign snp_hit = snp_act && (st_q[snp_idx] != LS_I) && (tag_q[snp_idx] == snp_tag);

  // snoop response: MSI downgrade/invalidate and combinational flush
  always_comb begin
    snp_we    = 1'b0;
    snp_state = st_q[snp_idx];
    snp_flush = 1'b0;
    if (snp_hit) begin
      case (cif.bus_msg_i)
        BUS_RD: begin
          if (st_q[snp_idx] == LS_M) begin
            snp_flush = 1'b1;
            snp_we    = 1'b1;
            snp_state = LS_S;
          end
        end
        BUS_RDX: begin
          snp_flush = (st_q[snp_idx] == LS_M);
          snp_we    = 1'b1;
          snp_state = LS_I;
        end
        BUS_UPGR: begin
          if (st_q[snp_idx] == LS_S) begin
            snp_we    = 1'b1;
            snp_state = LS_I;
          end
        end
        default: ;
      endcase
    end
  end

  // request FSM next state, bus request outputs and processor-side line update
  always_comb begin
    fsm_d    = fsm_q;
    msg_d    = msg_q;
    rdata_d  = rdata_q;
    ln_we    = 1'b0;
    ln_state = st_q[pr_idx];
    ln_tag   = tag_q[pr_idx];
    ln_data  = data_q[pr_idx];
    bus_req  = 1'b0;
    bus_msg  = BUS_RD;
    bus_addr = '0;
    pr_done  = 1'b0;
    pr_rdata = '0;
    wb_flush = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        // a same-index snoop this cycle postpones the lookup by one cycle
        if ((cif.pr_rd_i || cif.pr_wr_i) && !(snp_act && (snp_idx == pr_idx))) begin
          if (pr_hit && cif.pr_rd_i) begin
            rdata_d = data_q[pr_idx];
            fsm_d   = ST_DONE;
          end else if (pr_hit && (st_q[pr_idx] == LS_M)) begin
            ln_we    = 1'b1;
            ln_state = LS_M;
            ln_data  = cif.pr_wdata_i;
            fsm_d    = ST_DONE;
          end else if (pr_hit) begin
            msg_d = BUS_UPGR;
            fsm_d = ST_MISS;
          end else begin
            msg_d = cif.pr_rd_i ? BUS_RD : BUS_RDX;
            fsm_d = (st_q[pr_idx] == LS_M) ? ST_WB : ST_MISS;
          end
        end
      end
      ST_WB: begin
        bus_req  = 1'b1;
        bus_msg  = BUS_WB;
        bus_addr = {tag_q[pr_idx], pr_idx};
        wb_flush = 1'b1;
        // a snoop may already have taken the victim out of M; then no write-back is owed
        if (st_q[pr_idx] != LS_M) begin
          fsm_d = ST_MISS;
        end else if (cif.bus_gnt_i) begin
          ln_we    = 1'b1;
          ln_state = LS_I;
          fsm_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        bus_req  = 1'b1;
        bus_msg  = msg_q;
        bus_addr = cif.pr_addr_i;
        // an upgrade whose S copy was invalidated must fetch ownership with data
        if ((msg_q == BUS_UPGR) && snp_we && (snp_state == LS_I) && (snp_idx == pr_idx)) begin
          msg_d = BUS_RDX;
        end
        if (cif.bus_gnt_i) begin
          ln_we  = 1'b1;
          ln_tag = pr_tag;
          if (msg_q == BUS_RD) begin
            ln_state = LS_S;
            ln_data  = cif.bus_data_i;
            rdata_d  = cif.bus_data_i;
          end else begin
            ln_state = LS_M;
            ln_data  = cif.pr_wdata_i;
          end
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pr_done  = 1'b1;
        pr_rdata = cif.pr_rd_i ? rdata_q : '0;
        fsm_d    = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign cif.bus_req_o    = bus_req;
  assign cif.bus_msg_o    = bus_msg;
  assign cif.bus_addr_o   = bus_addr;
  assign cif.pr_done_o    = pr_done;
  assign cif.pr_rdata_o   = pr_rdata;
  assign cif.flush_o      = wb_flush || snp_flush;
  assign cif.flush_data_o = snp_flush ? data_q[snp_idx] :
                            wb_flush  ? data_q[pr_idx]  : '0;

  // FSM state, pending bus message and latched read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= ST_IDLE;
      msg_q   <= BUS_RD;
      rdata_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      msg_q   <= msg_d;
      rdata_q <= rdata_d;
    end
  end

  // line array: snoop updates and processor-side updates never target the
  // same line in one cycle (grant cycles are not snooped, lookups yield to snoops)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        st_q[i]   <= LS_I;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (snp_we) begin
        st_q[snp_idx] <= snp_state;
      end
      if (ln_we) begin
        st_q[pr_idx]   <= ln_state;
        tag_q[pr_idx]  <= ln_tag;
        data_q[pr_idx] <= ln_data;
      end
    end
  end

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed self-checking bench for msi_cache_ctrl (NUM_LINES=2, so 0x4 and
// 0x6 share index 0 with different tags).
module tb_msi_cache_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  msi_cache_ctrl_if #(.ADDR_SIZE(32), .CACHE_LINE_SIZE(128)) cif ();

  msi_cache_ctrl #(
    .NUM_LINES(2),
    .ADDR_SIZE(32),
    .CACHE_LINE_SIZE(128)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .cif   (cif)
  );

  always #5 clk = ~clk;

  task automatic clear_bus();
    cif.bus_gnt_i   = 1'b0;
    cif.bus_valid_i = 1'b0;
    cif.bus_msg_i   = 2'b00;
    cif.bus_addr_i  = '0;
    cif.bus_data_i  = '0;
  endtask

  task automatic drive_bus(input logic gnt, input logic [1:0] msg,
                           input logic [31:0] addr, input logic [127:0] data);
    cif.bus_gnt_i   = gnt;
    cif.bus_valid_i = 1'b1;
    cif.bus_msg_i   = msg;
    cif.bus_addr_i  = addr;
    cif.bus_data_i  = data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %0h expected 0", cif.bus_req_o); end
    checks++; if (cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %0h expected 0", cif.pr_done_o); end
    checks++; if (cif.flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush: got %0h expected 0", cif.flush_o); end
    checks++; if (cif.bus_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", cif.bus_addr_o); end
    checks++; if (cif.pr_rdata_o !== 128'h0) begin failures++; $display("FAIL reset_rdata: got %0h expected 0", cif.pr_rdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1) begin failures++; $display("FAIL cold_req: got %0h expected 1", cif.bus_req_o); end
    checks++; if (cif.bus_msg_o !== 2'b00) begin failures++; $display("FAIL cold_msg: got %0h expected 0", cif.bus_msg_o); end
    checks++; if (cif.bus_addr_o !== 32'h4) begin failures++; $display("FAIL cold_addr: got %0h expected 4", cif.bus_addr_o); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1 || cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL cold_wait: req=%0h done=%0h expected req=1 done=0", cif.bus_req_o, cif.pr_done_o); end
    drive_bus(1'b1, 2'b00, 32'h4, 128'hCAFE);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b1) begin failures++; $display("FAIL cold_done: got %0h expected 1", cif.pr_done_o); end
    checks++; if (cif.pr_rdata_o !== 128'hCAFE) begin failures++; $display("FAIL cold_rdata: got %0h expected cafe", cif.pr_rdata_o); end
    checks++; if (cif.bus_req_o !== 1'b0) begin failures++; $display("FAIL cold_req_drop: got %0h expected 0", cif.bus_req_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
    checks++; if (cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL cold_done_pulse: got %0h expected 0", cif.pr_done_o); end
  endtask

  task automatic test_upgrade();
    cif.pr_wr_i = 1'b1; cif.pr_addr_i = 32'h4; cif.pr_wdata_i = 128'h1111;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1 || cif.bus_msg_o !== 2'b10) begin failures++; $display("FAIL upg_msg: req=%0h msg=%0h expected req=1 msg=2", cif.bus_req_o, cif.bus_msg_o); end
    drive_bus(1'b1, 2'b10, 32'h4, 128'h0);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b1 || cif.pr_rdata_o !== 128'h0) begin failures++; $display("FAIL upg_done: done=%0h rdata=%0h expected done=1 rdata=0", cif.pr_done_o, cif.pr_rdata_o); end
    cif.pr_wr_i = 1'b0;
    @(negedge clk);
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    @(negedge clk);
    checks++; if (cif.pr_done_o !== 1'b1 || cif.bus_req_o !== 1'b0) begin failures++; $display("FAIL upg_hit: done=%0h req=%0h expected done=1 req=0", cif.pr_done_o, cif.bus_req_o); end
    checks++; if (cif.pr_rdata_o !== 128'h1111) begin failures++; $display("FAIL upg_hit_data: got %0h expected 1111", cif.pr_rdata_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snoop();
    drive_bus(1'b0, 2'b00, 32'h4, 128'h0);
    #1;
    checks++; if (cif.flush_o !== 1'b1) begin failures++; $display("FAIL snp_rd_flush: got %0h expected 1", cif.flush_o); end
    checks++; if (cif.flush_data_o !== 128'h1111) begin failures++; $display("FAIL snp_rd_data: got %0h expected 1111", cif.flush_data_o); end
    @(negedge clk);
    drive_bus(1'b0, 2'b01, 32'h4, 128'h0);
    #1;
    checks++; if (cif.flush_o !== 1'b0) begin failures++; $display("FAIL snp_s_rdx_flush: got %0h expected 0", cif.flush_o); end
    @(negedge clk);
    clear_bus();
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1 || cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL snp_inval_miss: req=%0h done=%0h expected req=1 done=0", cif.bus_req_o, cif.pr_done_o); end
    drive_bus(1'b1, 2'b00, 32'h4, 128'h2222);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b1 || cif.pr_rdata_o !== 128'h2222) begin failures++; $display("FAIL snp_refetch: done=%0h rdata=%0h expected done=1 rdata=2222", cif.pr_done_o, cif.pr_rdata_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dirty_evict();
    cif.pr_wr_i = 1'b1; cif.pr_addr_i = 32'h4; cif.pr_wdata_i = 128'h3333;
    @(negedge clk);
    drive_bus(1'b1, 2'b10, 32'h4, 128'h0);
    @(negedge clk);
    clear_bus();
    cif.pr_wr_i = 1'b0;
    @(negedge clk);
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h6;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1 || cif.bus_msg_o !== 2'b11) begin failures++; $display("FAIL wb_msg: req=%0h msg=%0h expected req=1 msg=3", cif.bus_req_o, cif.bus_msg_o); end
    checks++; if (cif.bus_addr_o !== 32'h4) begin failures++; $display("FAIL wb_addr: got %0h expected 4", cif.bus_addr_o); end
    checks++; if (cif.flush_o !== 1'b1 || cif.flush_data_o !== 128'h3333) begin failures++; $display("FAIL wb_flush: flush=%0h data=%0h expected flush=1 data=3333", cif.flush_o, cif.flush_data_o); end
    drive_bus(1'b1, 2'b11, 32'h4, 128'h0);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.bus_req_o !== 1'b1 || cif.bus_msg_o !== 2'b00 || cif.bus_addr_o !== 32'h6) begin failures++; $display("FAIL wb_then_rd: req=%0h msg=%0h addr=%0h expected req=1 msg=0 addr=6", cif.bus_req_o, cif.bus_msg_o, cif.bus_addr_o); end
    checks++; if (cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL wb_early_done: got %0h expected 0", cif.pr_done_o); end
    @(negedge clk);
    drive_bus(1'b1, 2'b00, 32'h6, 128'h6666);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b1 || cif.pr_rdata_o !== 128'h6666) begin failures++; $display("FAIL wb_done: done=%0h rdata=%0h expected done=1 rdata=6666", cif.pr_done_o, cif.pr_rdata_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_upgrade_lost();
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    @(negedge clk);
    checks++; if (cif.bus_msg_o !== 2'b00 || cif.flush_o !== 1'b0) begin failures++; $display("FAIL clean_victim: msg=%0h flush=%0h expected msg=0 flush=0", cif.bus_msg_o, cif.flush_o); end
    drive_bus(1'b1, 2'b00, 32'h4, 128'h4444);
    @(negedge clk);
    clear_bus();
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
    cif.pr_wr_i = 1'b1; cif.pr_addr_i = 32'h4; cif.pr_wdata_i = 128'h5555;
    @(negedge clk);
    checks++; if (cif.bus_msg_o !== 2'b10) begin failures++; $display("FAIL lost_pre_msg: got %0h expected 2", cif.bus_msg_o); end
    drive_bus(1'b0, 2'b01, 32'h4, 128'h0);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.bus_req_o !== 1'b1 || cif.bus_msg_o !== 2'b01) begin failures++; $display("FAIL lost_msg: req=%0h msg=%0h expected req=1 msg=1", cif.bus_req_o, cif.bus_msg_o); end
    drive_bus(1'b1, 2'b01, 32'h4, 128'h0);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b1) begin failures++; $display("FAIL lost_done: got %0h expected 1", cif.pr_done_o); end
    cif.pr_wr_i = 1'b0;
    @(negedge clk);
    drive_bus(1'b0, 2'b00, 32'h4, 128'h0);
    #1;
    checks++; if (cif.flush_o !== 1'b1 || cif.flush_data_o !== 128'h5555) begin failures++; $display("FAIL lost_line_m: flush=%0h data=%0h expected flush=1 data=5555", cif.flush_o, cif.flush_data_o); end
    @(negedge clk);
    clear_bus();
  endtask

  task automatic test_reset_mid_miss();
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h6;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1) begin failures++; $display("FAIL rst_pre_req: got %0h expected 1", cif.bus_req_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cif.bus_req_o !== 1'b0 || cif.bus_addr_o !== 32'h0) begin failures++; $display("FAIL rst_async: req=%0h addr=%0h expected req=0 addr=0", cif.bus_req_o, cif.bus_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    @(negedge clk);
    checks++; if (cif.bus_req_o !== 1'b1 || cif.pr_done_o !== 1'b0) begin failures++; $display("FAIL rst_lines_inval: req=%0h done=%0h expected req=1 done=0", cif.bus_req_o, cif.pr_done_o); end
    drive_bus(1'b1, 2'b00, 32'h4, 128'h7777);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_rdata_o !== 128'h7777) begin failures++; $display("FAIL rst_refetch: got %0h expected 7777", cif.pr_rdata_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snoop_delay();
    cif.pr_rd_i = 1'b1; cif.pr_addr_i = 32'h4;
    drive_bus(1'b0, 2'b00, 32'h8, 128'h0);
    @(negedge clk);
    clear_bus();
    checks++; if (cif.pr_done_o !== 1'b0 || cif.bus_req_o !== 1'b0) begin failures++; $display("FAIL delay_stall: done=%0h req=%0h expected done=0 req=0", cif.pr_done_o, cif.bus_req_o); end
    @(negedge clk);
    checks++; if (cif.pr_done_o !== 1'b1 || cif.pr_rdata_o !== 128'h7777) begin failures++; $display("FAIL delay_done: done=%0h rdata=%0h expected done=1 rdata=7777", cif.pr_done_o, cif.pr_rdata_o); end
    cif.pr_rd_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    cif.pr_rd_i    = 1'b0;
    cif.pr_wr_i    = 1'b0;
    cif.pr_addr_i  = '0;
    cif.pr_wdata_i = '0;
    clear_bus();
    test_reset();
    test_cold_read();
    test_upgrade();
    test_snoop();
    test_dirty_evict();
    test_upgrade_lost();
    test_reset_mid_miss();
    test_snoop_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
